lut8_prog_neuron: RTL and testbench

LUT8_PROG_NEURON -- requirements
Module: lut8_prog_neuron

---
 rtl/lut8_prog_neuron.sv | 79 +++++++
 tb/tb_lut8_prog_neuron.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lut8_prog_neuron.sv
// lut8_prog_neuron: programmable 8-input LUT neuron with a shadow/active table pair.
// Tables are reloaded beat by beat, and the whole table is committed atomically on the final beat.
module lut8_prog_neuron #(
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_addr,
  output logic             out_valid,
  output logic             out_bit
);
  localparam int NB = 256 / CFG_W;
  localparam int CW = $clog2(NB);

  typedef enum logic [1:0] {UNPROG, LOAD, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [255:0]    shadow_q, shadow_d, active_q, active_d;
  logic [1:0]      rs_q, rs_d;
  logic            prog_q, prog_d, done_q, done_d, ov_q, ov_d, ob_q, ob_d;
  logic            start, accept, last;
  logic [7:0]      base;

  // rs_q keeps the FSM parked for two clean edges after rst is released
  always_comb begin
    rs_d     = {rs_q[0], 1'b0};
    start    = cfg_start & ~rs_q[1];
    accept   = cfg_valid & (state_q == LOAD) & ~start;
    last     = accept & (cnt_q == CW'(NB - 1));
    base     = 8'(cnt_q) * 8'(CFG_W);
    shadow_d = shadow_q;
    if (accept) shadow_d[base +: CFG_W] = cfg_data;
    active_d = last ? shadow_d : active_q;
    cnt_d    = start ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    state_d  = start ? LOAD : last ? ACTIVE : state_q;
    prog_d   = prog_q | last;
    done_d   = last;
    ov_d     = in_valid & prog_q;
    ob_d     = ov_d ? active_q[in_addr] : ob_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q     <= 2'b11;
      state_q  <= UNPROG;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      prog_q   <= 1'b0;
      done_q   <= 1'b0;
      ov_q     <= 1'b0;
      ob_q     <= 1'b0;
    end else begin
      rs_q     <= rs_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      prog_q   <= prog_d;
      done_q   <= done_d;
      ov_q     <= ov_d;
      ob_q     <= ob_d;
    end
  end

  assign cfg_ready = state_q == LOAD;
  assign cfg_done  = done_q;
  assign in_ready  = prog_q;
  assign out_valid = ov_q;
  assign out_bit   = ob_q;
endmodule

// File: tb/tb_lut8_prog_neuron.sv
// tb_lut8_prog_neuron: directed checks of table load, commit timing, reload, restart and reset.
module tb_lut8_prog_neuron;
  logic        clk = 0, rst = 1;
  logic        cfg_start = 0, cfg_valid = 0, in_valid = 0;
  logic [7:0]  cfg_data = 0, in_addr = 0;
  logic        cfg_ready, cfg_done, in_ready, out_valid, out_bit;
  logic        s32 = 0, v32 = 0, iv32 = 0;
  logic [31:0] d32 = 0;
  logic [7:0]  a32 = 0;
  logic        rdy32, done32, ir32, ov32, ob32;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  lut8_prog_neuron #(.CFG_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .out_valid(out_valid), .out_bit(out_bit)
  );

  lut8_prog_neuron #(.CFG_W(32)) dut32 (
    .clk(clk), .rst(rst), .cfg_start(s32), .cfg_valid(v32), .cfg_ready(rdy32),
    .cfg_data(d32), .cfg_done(done32), .in_valid(iv32), .in_ready(ir32),
    .in_addr(a32), .out_valid(ov32), .out_bit(ob32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start8();
    cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("ready_after_start", cfg_ready, 1);
  endtask

  task automatic beats32(input logic [7:0] d, input bit gaps);
    for (int k = 0; k < 32; k++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        cfg_valid = 0;
        tick();
        chk("done_in_gap", cfg_done, 0);
      end
      cfg_valid = 1;
      cfg_data  = d;
      tick();
      chk(k == 31 ? "done_final" : "done_early", cfg_done, k == 31);
    end
    cfg_valid = 0;
    tick();
    chk("done_one_cycle", cfg_done, 0);
    chk("ready_after_commit", cfg_ready, 0);
  endtask

  task automatic look(input logic [7:0] a, input logic exp);
    in_valid = 1;
    in_addr  = a;
    tick();
    in_valid = 0;
    chk("look_valid", out_valid, 1);
    chk("look_bit", out_bit, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    rst = 0;
    repeat (3) tick();
    in_valid = 1;
    in_addr  = 8'h00;
    tick();
    chk("unprog_in_ready", in_ready, 0);
    chk("unprog_ov_00", out_valid, 0);
    in_addr = 8'hFF;
    tick();
    chk("unprog_ov_ff", out_valid, 0);
    in_valid = 0;
    tick();
    chk("unprog_ov_idle", out_valid, 0);

    start8();
    beats32(8'hA5, 1);
    chk("prog_in_ready", in_ready, 1);
    look(8'h00, 1);
    look(8'h01, 0);
    look(8'h05, 1);
    look(8'h07, 1);
    tick();
    chk("idle_ov", out_valid, 0);
    chk("idle_hold_bit", out_bit, 1);

    in_valid = 1;
    in_addr  = 8'h00;
    cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("reload_start_bit", out_bit, 1);
    for (int k = 0; k < 32; k++) begin
      cfg_valid = 1;
      cfg_data  = 8'h00;
      tick();
      chk("reload_ov", out_valid, 1);
      chk(k == 31 ? "reload_commit_bit" : "reload_old_bit", out_bit, 1);
      chk("reload_done", cfg_done, k == 31);
    end
    cfg_valid = 0;
    tick();
    chk("reload_new_bit", out_bit, 0);
    tick();
    chk("reload_new_bit2", out_bit, 0);
    in_valid = 0;
    tick();

    start8();
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1;
      cfg_data  = 8'h3C;
      tick();
      chk("restart_pre_done", cfg_done, 0);
    end
    cfg_start = 1;
    cfg_data  = 8'h00;
    tick();
    cfg_start = 0;
    cfg_valid = 0;
    chk("restart_collide_done", cfg_done, 0);
    look(8'h00, 0);
    beats32(8'hFF, 0);
    look(8'h00, 1);
    look(8'h37, 1);
    look(8'hFF, 1);

    start8();
    for (int k = 0; k < 20; k++) begin
      cfg_valid = 1;
      cfg_data  = 8'h55;
      tick();
    end
    cfg_valid = 0;
    rst = 1;
    tick();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_cfg_ready", cfg_ready, 0);
    chk("midrst_out_bit", out_bit, 0);
    rst = 0;
    repeat (3) tick();
    chk("postrst_in_ready", in_ready, 0);
    in_valid = 1;
    in_addr  = 8'h00;
    tick();
    in_valid = 0;
    chk("postrst_drop", out_valid, 0);
    start8();
    beats32(8'h0F, 1);
    look(8'h00, 1);
    look(8'h04, 0);
    look(8'h0B, 1);

    s32 = 1;
    tick();
    s32 = 0;
    chk("w32_ready", rdy32, 1);
    for (int k = 0; k < 8; k++) begin
      v32 = 1;
      d32 = (k == 7) ? 32'h8000_0000 : 32'h0;
      tick();
      chk("w32_done", done32, k == 7);
    end
    v32 = 0;
    tick();
    chk("w32_done_once", done32, 0);
    chk("w32_in_ready", ir32, 1);
    iv32 = 1;
    a32  = 8'hFF;
    tick();
    chk("w32_ff_valid", ov32, 1);
    chk("w32_ff_bit", ob32, 1);
    a32 = 8'hFE;
    tick();
    chk("w32_fe_bit", ob32, 0);
    iv32 = 0;
    tick();
    chk("w32_idle_ov", ov32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
